// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, round count, S-box table, encryptor FSM states
// and round-key extraction from the packed expanded-key bus.
package aes_pkg;

    localparam int NR = 10;
    localparam int BW = 128;
    localparam int KW = BW * (NR + 1);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } enc_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [BW-1:0] round_key(input logic [KW-1:0] keys, input logic [3:0] idx);
        return keys[BW*idx +: BW];
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skippable
// for the last round) and AddRoundKey. Byte 0 of the column-major state sits in [127:120].
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [BW-1:0] state_in,
    input  logic [BW-1:0] key,
    input  logic          bypass_mix,
    output logic [BW-1:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        sb = '{default: 8'h00};
        sr = '{default: 8'h00};
        mc = '{default: 8'h00};
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state_in[BW-1-8*i -: 8]];
        end
        // Row r of the output column c takes the byte from column (c + r) mod 4
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            state_out[BW-1-8*i -: 8] = (bypass_mix ? sr[i] : mc[i]) ^ key[BW-1-8*i -: 8];
        end
    end

endmodule

// File: rtl/cbc_encrypt_iter.sv
// Iterative AES-128 CBC encryptor: one block in flight, ten rounds on a shared round
// datapath. Define CBC_ENC_BLOCK_CNT_EN to add the saturating block_count output.
module cbc_encrypt_iter #(
    parameter int NR = aes_pkg::NR,
    parameter int BW = aes_pkg::BW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BW*(NR+1)-1:0] round_keys,
    input  logic [BW-1:0]       iv,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_first,
    input  logic [BW-1:0]       plain_text,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BW-1:0]       cipher_text
`ifdef CBC_ENC_BLOCK_CNT_EN
    ,
    output logic [31:0]         block_count
`endif
);
    import aes_pkg::*;

    enc_state_t    state;
    logic [3:0]    round_cnt;
    logic [BW-1:0] state_reg;
    logic [BW-1:0] chain_reg;
    logic [BW-1:0] round_out;
    logic [BW-1:0] cur_key;
    logic          accept;

    assign accept  = (state == IDLE) && in_ready && in_valid;
    assign cur_key = round_key(round_keys, round_cnt);

    // round_cnt reaches 10 on entry to FINAL, so the same key select serves the last round
    aes_enc_round u_round (
        .state_in   (state_reg),
        .key        (cur_key),
        .bypass_mix (state == FINAL),
        .state_out  (round_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            round_cnt   <= '0;
            state_reg   <= '0;
            chain_reg   <= '0;
            cipher_text <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_reg <= plain_text ^ (in_first ? iv : chain_reg) ^ round_key(round_keys, 4'd0);
                        round_cnt <= 4'd1;
                        in_ready  <= 1'b0;
                        state     <= ROUND;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    round_cnt <= round_cnt + 4'd1;
                    if (round_cnt == 4'(NR - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    cipher_text <= round_out;
                    chain_reg   <= round_out;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CBC_ENC_BLOCK_CNT_EN
    // A new message restarts the count at one; otherwise count up and stick at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_count <= '0;
        end else if (accept) begin
            if (in_first) begin
                block_count <= 32'd1;
            end else if (block_count != 32'hFFFF_FFFF) begin
                block_count <= block_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cbc_encrypt_iter.sv
// Scoreboard bench for cbc_encrypt_iter using the NIST SP800-38A CBC-AES128 vectors;
// covers latency, backpressure, new-message chaining and async abort.
module tb_cbc_encrypt_iter;

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] K4  = 128'hef44a541a8525b7fb671253bdb0bad00;
    localparam logic [127:0] K5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] K6  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    localparam logic [127:0] K7  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    localparam logic [127:0] K8  = 128'head27321b58dbad2312bf5607f8d292f;
    localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] CT3 = 128'h73bed6b8e3c1743b7116e69e22229516;
    localparam logic [127:0] CT4 = 128'h3ff1caa1681fac09120eca307586e1a7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1407:0] round_keys;
    logic [127:0]  iv;
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic [127:0]  plain_text;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  cipher_text;
`ifdef CBC_ENC_BLOCK_CNT_EN
    logic [31:0]   block_count;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    logic [127:0] expQueue [$];

    cbc_encrypt_iter dut (
        .clk         (clk),
        .reset       (reset),
        .round_keys  (round_keys),
        .iv          (iv),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .plain_text  (plain_text),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text)
`ifdef CBC_ENC_BLOCK_CNT_EN
        ,
        .block_count (block_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one block, wait for it to be accepted, then scramble the sampled inputs
    task automatic applyStimulus(input logic [127:0] pt, input logic first, input logic [127:0] expCt);
        int waitCycles = 0;
        @(negedge clk);
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
            return;
        end
        plain_text = pt;
        iv         = IV;
        in_first   = first;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_first   = 1'($urandom_range(0, 1));
        plain_text = {$urandom, $urandom, $urandom, $urandom};
        iv         = {$urandom, $urandom, $urandom, $urandom};
        expQueue.push_back(expCt);
    endtask

    // Wait for the result, check it against the scoreboard, hold it, then release it
    task automatic collectOutput(input int holdCycles);
        int cycles = 1;
        logic [127:0] expCt;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!out_valid || expQueue.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL output_timeout: out_valid %b after %0d cycles, queue %0d", out_valid, cycles, expQueue.size());
            return;
        end
        expCt = expQueue.pop_front();
        checkOutput("latency", 128'(cycles), 128'd11);
        checkOutput("cipher_text", cipher_text, expCt);
        checkOutput("in_ready_done", 128'(in_ready), 128'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_cipher", cipher_text, expCt);
            checkOutput("hold_out_valid", 128'(out_valid), 128'd1);
            checkOutput("hold_in_ready", 128'(in_ready), 128'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_clear", 128'(out_valid), 128'd0);
        checkOutput("in_ready_set", 128'(in_ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        round_keys = {K10, K9, K8, K7, K6, K5, K4, K3, K2, K1, K0};
        iv         = IV;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        plain_text = '0;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_cipher", cipher_text, 128'd0);
        checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
`ifdef CBC_ENC_BLOCK_CNT_EN
        checkOutput("rst_block_count", 128'(block_count), 128'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_rst", 128'(in_ready), 128'd1);

        applyStimulus(PT1, 1'b1, CT1);
        collectOutput(0);
`ifdef CBC_ENC_BLOCK_CNT_EN
        checkOutput("block_count_b1", 128'(block_count), 128'd1);
`endif
        applyStimulus(PT2, 1'b0, CT2);
        collectOutput(20);
`ifdef CBC_ENC_BLOCK_CNT_EN
        checkOutput("block_count_b2", 128'(block_count), 128'd2);
`endif
        applyStimulus(PT1, 1'b1, CT1);
        collectOutput(0);
`ifdef CBC_ENC_BLOCK_CNT_EN
        checkOutput("block_count_new_msg", 128'(block_count), 128'd1);
`endif
        applyStimulus(PT2, 1'b0, CT2);
        collectOutput(0);
        applyStimulus(PT3, 1'b0, CT3);
        collectOutput(2);
        applyStimulus(PT4, 1'b0, CT4);
        collectOutput(0);
`ifdef CBC_ENC_BLOCK_CNT_EN
        checkOutput("block_count_b4", 128'(block_count), 128'd4);
`endif

        applyStimulus(PT1, 1'b1, CT1);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
        checkOutput("abort_cipher", cipher_text, 128'd0);
        checkOutput("abort_in_ready", 128'(in_ready), 128'd0);
        expQueue.delete();
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(PT1, 1'b1, CT1);
        collectOutput(0);
`ifdef CBC_ENC_BLOCK_CNT_EN
        checkOutput("block_count_after_abort", 128'(block_count), 128'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
